// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between instruction fetch and data access.
// Optional fairness (bounded data run while a fetch waits) is enabled with `define MEM_ARB_FAIR_EN.
`default_nettype none

module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MAX_DM_RUN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ready_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_wmask_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_ready_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic                stall_if_o,
    output logic                stall_mem_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_DM  = 2'd2,
        DRAIN_IF = 2'd3
    } state_t;

    state_t              state_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wmask_q;

    logic decide;
    logic if_eligible;
    logic fetch_turn;
    logic grant_dm;
    logic grant_if;

`ifdef MEM_ARB_FAIR_EN
    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
    logic [RUN_W-1:0] run_q;

    // Counts data grants that overtook a waiting fetch; saturates so a flush cannot skip the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else if (!if_req_i || grant_if) begin
            run_q <= '0;
        end else if (grant_dm && (run_q < RUN_W'(MAX_DM_RUN))) begin
            run_q <= run_q + 1'b1;
        end
    end
`endif

    always_comb begin
        decide      = (state_q == IDLE) || mem_ack_i;
        if_eligible = if_req_i && !flush_i;
`ifdef MEM_ARB_FAIR_EN
        fetch_turn  = if_eligible && (run_q >= RUN_W'(MAX_DM_RUN));
`else
        fetch_turn  = 1'b0;
`endif
        grant_dm    = decide && dm_req_i && !fetch_turn;
        grant_if    = decide && if_eligible && !grant_dm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else if (grant_dm) begin
            state_q     <= BUSY_DM;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            mem_wmask_q <= dm_wmask_i;
        end else if (grant_if) begin
            state_q     <= BUSY_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else if (decide) begin
            state_q <= IDLE;
        end else if ((state_q == BUSY_IF) && flush_i) begin
            // The abandoned fetch stays on the bus until the memory acknowledges it.
            state_q <= DRAIN_IF;
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

    assign if_ready_o  = mem_ack_i && (state_q == BUSY_IF) && !flush_i;
    assign dm_ready_o  = mem_ack_i && (state_q == BUSY_DM);
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;

    assign stall_if_o  = if_req_i && !if_ready_o;
    assign stall_mem_o = dm_req_i && !dm_ready_o;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (command queue checked at each grant).
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int MAX_DM_RUN = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                if_req_i = 1'b0;
    logic [ADDR_W-1:0]   if_addr_i = '0;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                if_ready_o;
    logic                dm_req_i = 1'b0;
    logic                dm_we_i = 1'b0;
    logic [ADDR_W-1:0]   dm_addr_i = '0;
    logic [DATA_W-1:0]   dm_wdata_i = '0;
    logic [DATA_W/8-1:0] dm_wmask_i = '0;
    logic [DATA_W-1:0]   dm_rdata_o;
    logic                dm_ready_o;
    logic                flush_i = 1'b0;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic [DATA_W/8-1:0] mem_wmask_o;
    logic [DATA_W-1:0]   mem_rdata_i = '0;
    logic                mem_ack_i = 1'b0;
    logic                stall_if_o;
    logic                stall_mem_o;

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wmask;
        logic                is_if;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt;
    int   waited;

    mem_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DM_RUN(MAX_DM_RUN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_wmask_i(dm_wmask_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W/8-1:0] wmask,
                            input logic is_if);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.wmask = wmask; c.is_if = is_if;
        exp_q.push_back(c);
    endtask

    // Waits (bounded) for mem_req, then pops the expected command and compares it.
    task automatic wait_grant(input string tag, input bit is_if);
        cmd_t c;
        waited = 0;
        forever begin
            @(negedge clk);
            if (is_if ? stall_if_o : stall_mem_o) stall_cnt++;
            if (mem_req_o) break;
            if (waited >= 20) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                return;
            end
            tick();
            waited++;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        c = exp_q.pop_front();
        check({tag, "_we"},    64'(mem_we_o),    64'(c.we));
        check({tag, "_addr"},  64'(mem_addr_o),  64'(c.addr));
        check({tag, "_wdata"}, 64'(mem_wdata_o), 64'(c.wdata));
        check({tag, "_wmask"}, 64'(mem_wmask_o), 64'(c.wmask));
    endtask

    // Full transaction: ack arrives lat (>=1) cycles after mem_req; requester drops on ready.
    task automatic serve(input string tag, input int lat, input logic [DATA_W-1:0] rd, input bit is_if);
        wait_grant(tag, is_if);
        for (int i = 0; i < lat - 1; i++) begin
            tick();
            @(negedge clk);
            if (is_if ? stall_if_o : stall_mem_o) stall_cnt++;
        end
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        if (is_if) if_req_i = 1'b0;
        else       dm_req_i = 1'b0;
        @(negedge clk);
        if (is_if ? stall_if_o : stall_mem_o) stall_cnt++;
        check({tag, "_if_ready"}, 64'(if_ready_o), 64'(is_if));
        check({tag, "_dm_ready"}, 64'(dm_ready_o), 64'(!is_if));
        check({tag, "_rdata"}, 64'(is_if ? if_rdata_o : dm_rdata_o), 64'(rd));
        tick();
        mem_ack_i = 1'b0;
    endtask

    initial begin
        int  run;
        bit  exp_if;
        cmd_t c;

        // Reset state
        #3;
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_mem_we", 64'(mem_we_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_stalls", 64'({stall_if_o, stall_mem_o, if_ready_o, dm_ready_o}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch alone: ack 2 cycles after mem_req, stall_if high 3 cycles
        if_req_i = 1'b1; if_addr_i = 32'h100;
        push_cmd(1'b0, 32'h100, '0, '0, 1'b1);
        stall_cnt = 0;
        serve("fetch", 2, 32'h0050_0093, 1'b1);
        check("fetch_stall_cycles", 64'(stall_cnt), 64'd3);
        @(negedge clk);
        check("fetch_single_pulse", 64'(if_ready_o), 64'd0);
        check("fetch_idle", 64'(mem_req_o), 64'd0);
        tick();

        // Simultaneous requests: data first, fetch the cycle after the data ack
        if_req_i = 1'b1; if_addr_i = 32'h104;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2000; dm_wdata_i = '0; dm_wmask_i = '0;
        push_cmd(1'b0, 32'h2000, '0, '0, 1'b0);
        push_cmd(1'b0, 32'h104, '0, '0, 1'b1);
        stall_cnt = 0;
        serve("simul_load", 1, 32'h1111_2222, 1'b0);
        check("simul_load_latency", 64'(waited), 64'd1);
        serve("simul_fetch", 1, 32'h3333_4444, 1'b1);
        check("simul_fetch_no_bubble", 64'(waited), 64'd0);

        // Flush mid-fetch: drain, suppress ready, then refetch 0x200 with no bubble
        if_req_i = 1'b1; if_addr_i = 32'h180;
        push_cmd(1'b0, 32'h180, '0, '0, 1'b1);
        wait_grant("flush_orig", 1'b1);
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_req_held", 64'(mem_req_o), 64'd1);
        tick();
        flush_i = 1'b0; if_addr_i = 32'h200;
        @(negedge clk);
        check("drain_req_held", 64'({mem_req_o, if_ready_o, stall_if_o}), 64'b101);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        check("drain_ack_no_ready", 64'({mem_req_o, if_ready_o}), 64'b10);
        push_cmd(1'b0, 32'h200, '0, '0, 1'b1);
        tick();
        mem_ack_i = 1'b0;
        serve("refetch", 1, 32'h0000_0013, 1'b1);
        check("refetch_no_bubble", 64'(waited), 64'd0);

        // Flush coinciding with ack: word discarded, back to idle
        if_req_i = 1'b1; if_addr_i = 32'h300;
        push_cmd(1'b0, 32'h300, '0, '0, 1'b1);
        wait_grant("flushack", 1'b1);
        tick();
        flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        check("flushack_no_ready", 64'(if_ready_o), 64'd0);
        tick();
        flush_i = 1'b0; mem_ack_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk);
        check("flushack_idle", 64'(mem_req_o), 64'd0);
        tick();

        // Stray ack while idle is ignored
        mem_ack_i = 1'b1;
        @(negedge clk);
        check("stray_ack_ready", 64'({if_ready_o, dm_ready_o}), 64'd0);
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("stray_ack_idle", 64'(mem_req_o), 64'd0);
        tick();

        // Store interrupted by asynchronous reset
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h3000;
        dm_wdata_i = 32'hDEAD_BEEF; dm_wmask_i = 4'hF;
        push_cmd(1'b1, 32'h3000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wait_grant("store", 1'b0);
        tick();
        #2;
        rst_n = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        #1;
        check("rst_mid_req", 64'(mem_req_o), 64'd0);
        check("rst_mid_we", 64'(mem_we_o), 64'd0);
        check("rst_mid_addr", 64'(mem_addr_o), 64'd0);
        check("rst_mid_wdata", 64'(mem_wdata_o), 64'd0);
        check("rst_mid_wmask", 64'(mem_wmask_o), 64'd0);
        check("rst_mid_flags", 64'({if_ready_o, dm_ready_o, stall_if_o, stall_mem_o}), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Continuous competition: ack in the same cycle as every command
        run = 0;
        for (int i = 0; i < 15; i++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_if = (run == MAX_DM_RUN);
            run    = exp_if ? 0 : run + 1;
`else
            exp_if = 1'b0;
`endif
            push_cmd(1'b0, exp_if ? 32'h500 : 32'h4000, '0, '0, exp_if);
        end
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h4000; dm_wdata_i = '0; dm_wmask_i = '0;
        if_req_i = 1'b1; if_addr_i = 32'h500;
        tick();
        for (int i = 0; i < 15; i++) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'(i);
            @(negedge clk);
            c = exp_q.pop_front();
            check($sformatf("fair%0d_req", i), 64'(mem_req_o), 64'd1);
            check($sformatf("fair%0d_addr", i), 64'(mem_addr_o), 64'(c.addr));
            check($sformatf("fair%0d_ready", i), 64'({if_ready_o, dm_ready_o}),
                  64'({c.is_if, !c.is_if}));
            if (i == 14) begin
                dm_req_i = 1'b0;
                if_req_i = 1'b0;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("fair_end_idle", 64'(mem_req_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
